// File: rtl/except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: CP0 register addresses,
// exception type codes, raw flag positions and the priority encoder.
package except_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID   = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  localparam int RAW_SYSCALL_BIT = 8;
  localparam int RAW_INVALID_BIT = 9;
  localparam int RAW_TRAP_BIT    = 10;
  localparam int RAW_ERET_BIT    = 11;

  // Software may only write IP[1:0] (bits 9:8), IV (22) and WP (23) of Cause.
  localparam logic [31:0] CAUSE_WRITE_MASK = 32'h00c0_0300;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } cp0_view_t;

  function automatic logic cp0_int_pending(input cp0_view_t v);
    return ((v.cause[15:8] & v.status[15:8]) != 8'h00) && v.status[0] && !v.status[1];
  endfunction

  function automatic logic [31:0] select_exc(input logic int_pending, input logic [31:0] raw);
    logic [31:0] code;
    code = EXC_NONE;
    if (int_pending)                code = EXC_INTERRUPT;
    else if (raw[RAW_SYSCALL_BIT])  code = EXC_SYSCALL;
    else if (raw[RAW_INVALID_BIT])  code = EXC_INVALID;
    else if (raw[RAW_TRAP_BIT])     code = EXC_TRAP;
    else if (raw[RAW_ERET_BIT])     code = EXC_ERET;
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_cp0_fwd.sv
// cp0_fwd unit: combinational Status/Cause/EPC bypass of a same-cycle WB-stage mtc0,
// kept standalone so the EX-stage mfc0 path can reuse it.
module except_ctrl_cp0_fwd
  import except_ctrl_pkg::*;
(
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] status_fwd,
  output logic [31:0] cause_fwd,
  output logic [31:0] epc_fwd
);

  always_comb begin
    status_fwd = status;
    cause_fwd  = cause;
    epc_fwd    = epc;
    if (we) begin
      if (waddr == CP0_REG_STATUS) status_fwd = wdata;
      if (waddr == CP0_REG_EPC)    epc_fwd    = wdata;
      // Cause is only partially writable; hardware-owned bits keep the CP0 value.
      if (waddr == CP0_REG_CAUSE)
        cause_fwd = (cause & ~CAUSE_WRITE_MASK) | (wdata & CAUSE_WRITE_MASK);
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: picks one exception by priority, pulses it into CP0
// with a pipeline flush and redirect PC, then drains squashed instructions.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          DRAIN_CYCLES = 2              // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] excepttype_raw_i,
  input  logic [31:0] current_inst_address_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_address_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [1:0]  state;
  logic [3:0]  drain_cnt;
  cp0_view_t   eff;
  logic        int_pend;
  logic [31:0] sel_type;
  logic [31:0] sel_pc;
  logic        take;

  logic unused_bits;
  assign unused_bits = ^{excepttype_raw_i[31:12], excepttype_raw_i[7:0],
                         eff.status[31:16], eff.status[7:2],
                         eff.cause[31:16], eff.cause[7:0]};

  except_ctrl_cp0_fwd u_cp0_fwd (
    .status     (cp0_status_i),
    .cause      (cp0_cause_i),
    .epc        (cp0_epc_i),
    .we         (wb_cp0_we_i),
    .waddr      (wb_cp0_waddr_i),
    .wdata      (wb_cp0_data_i),
    .status_fwd (eff.status),
    .cause_fwd  (eff.cause),
    .epc_fwd    (eff.epc)
  );

  always_comb begin
    int_pend = cp0_int_pending(eff);
    sel_type = select_exc(int_pend, excepttype_raw_i);
    sel_pc   = (sel_type == EXC_ERET) ? eff.epc : EXC_VECTOR;
    take     = (state == ST_IDLE) && mem_valid_i && (sel_type != EXC_NONE);
  end

  // FLUSH is a single-cycle pulse state; DRAIN ignores MEM until the counter expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state                  <= ST_IDLE;
      drain_cnt              <= 4'd0;
      excepttype_o           <= EXC_NONE;
      current_inst_address_o <= 32'h0;
      is_in_delayslot_o      <= 1'b0;
      flush_o                <= 1'b0;
      new_pc_o               <= 32'h0;
      busy_o                 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state                  <= ST_FLUSH;
            excepttype_o           <= sel_type;
            current_inst_address_o <= current_inst_address_i;
            is_in_delayslot_o      <= is_in_delayslot_i;
            flush_o                <= 1'b1;
            new_pc_o               <= sel_pc;
            busy_o                 <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state        <= ST_DRAIN;
          excepttype_o <= EXC_NONE;
          flush_o      <= 1'b0;
          drain_cnt    <= DRAIN_LOAD;
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          excepttype_o <= EXC_NONE;
          flush_o      <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: table-driven vectors through a scoreboard queue,
// plus hand sequences for drain squashing, interrupt gating by mem_valid and mid-drain reset.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] raw;
  logic [31:0] pc;
  logic        ds;
  logic [31:0] status, cause, epc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] excepttype_o, current_inst_address_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  except_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_valid_i            (mem_valid),
    .excepttype_raw_i       (raw),
    .current_inst_address_i (pc),
    .is_in_delayslot_i      (ds),
    .cp0_status_i           (status),
    .cp0_cause_i            (cause),
    .cp0_epc_i              (epc),
    .wb_cp0_we_i            (wb_we),
    .wb_cp0_waddr_i         (wb_addr),
    .wb_cp0_data_i          (wb_data),
    .excepttype_o           (excepttype_o),
    .current_inst_address_o (current_inst_address_o),
    .is_in_delayslot_o      (is_in_delayslot_o),
    .flush_o                (flush_o),
    .new_pc_o               (new_pc_o),
    .busy_o                 (busy_o)
  );

  typedef struct {
    string       name;
    logic [31:0] status, cause, epc, raw;
    logic        ds, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] exp_type, exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] typ, npc, addr;
    logic        ds;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[16];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    raw       = 32'h0;
    wb_we     = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'h0;
  endtask

  task automatic apply_stimulus(input vec_t v, input logic [31:0] vpc);
    exp_t e;
    int   busy_cnt;
    @(negedge clk);
    status = v.status; cause = v.cause; epc = v.epc; raw = v.raw;
    pc = vpc; ds = v.ds; wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
    mem_valid = 1'b1;
    e.typ = v.exp_type; e.npc = v.exp_pc; e.addr = vpc; e.ds = v.ds;
    sbq.push_back(e);
    @(negedge clk);
    idle_inputs();
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected one entry", v.name);
    end else begin
      e = sbq.pop_front();
      check_output({v.name, " type"}, excepttype_o, e.typ);
      check_output({v.name, " flush"}, {31'h0, flush_o}, {31'h0, e.typ != 32'h0});
      if (e.typ != 32'h0) begin
        check_output({v.name, " new_pc"}, new_pc_o, e.npc);
        check_output({v.name, " addr"}, current_inst_address_o, e.addr);
        check_output({v.name, " ds"}, {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
        busy_cnt = 0;
        while (busy_o && busy_cnt < 20) begin
          busy_cnt++;
          @(negedge clk);
          if (busy_cnt == 1)
            check_output({v.name, " flush one cycle"}, {31'h0, flush_o}, 32'h0);
        end
        check_output({v.name, " busy cycles"}, busy_cnt, 32'd3);
      end else begin
        check_output({v.name, " busy"}, {31'h0, busy_o}, 32'h0);
      end
    end
  endtask

  task automatic drive_syscall(input logic [31:0] vpc);
    mem_valid = 1'b1; raw = 32'h100; pc = vpc; ds = 1'b0;
  endtask

  initial begin
    //            name           status        cause         epc    raw           ds we  addr   wdata         type   pc
    vecs[0]  = '{"syscall",      32'h1000_0000, 32'h0,        32'h0,  32'h100,      0, 0, 5'd0,  32'h0,        32'h8, 32'h20};
    vecs[1]  = '{"eret_fwd",     32'h1000_0000, 32'h0,        32'h40, 32'h800,      0, 1, 5'd14, 32'h800,      32'he, 32'h800};
    vecs[2]  = '{"eret_plain",   32'h1000_0000, 32'h0,        32'h40, 32'h800,      1, 0, 5'd0,  32'h0,        32'he, 32'h40};
    vecs[3]  = '{"int_prio",     32'h401,       32'h400,      32'h0,  32'h200,      0, 0, 5'd0,  32'h0,        32'h1, 32'h20};
    vecs[4]  = '{"int_fwd_off",  32'h401,       32'h400,      32'h0,  32'h200,      0, 1, 5'd12, 32'h400,      32'ha, 32'h20};
    vecs[5]  = '{"exl_no_int",   32'h403,       32'h400,      32'h0,  32'h0,        0, 0, 5'd0,  32'h0,        32'h0, 32'h0};
    vecs[6]  = '{"exl_trap",     32'h403,       32'h400,      32'h0,  32'h400,      0, 0, 5'd0,  32'h0,        32'hd, 32'h20};
    vecs[7]  = '{"cause_fwd",    32'h301,       32'h0,        32'h0,  32'h0,        0, 1, 5'd13, 32'h100,      32'h1, 32'h20};
    vecs[8]  = '{"cause_ro_bit", 32'h401,       32'h0,        32'h0,  32'h0,        0, 1, 5'd13, 32'h400,      32'h0, 32'h0};
    vecs[9]  = '{"prio_all",     32'h1000_0000, 32'h0,        32'h0,  32'hf00,      0, 0, 5'd0,  32'h0,        32'h8, 32'h20};
    vecs[10] = '{"inv_over_rest",32'h1000_0000, 32'h0,        32'h0,  32'he00,      1, 0, 5'd0,  32'h0,        32'ha, 32'h20};
    vecs[11] = '{"ignored_bits", 32'h1000_0000, 32'h0,        32'h0,  32'hffff_f0ff,0, 0, 5'd0,  32'h0,        32'h0, 32'h0};
    vecs[12] = '{"wb_we_low",    32'h1000_0000, 32'h400,      32'h0,  32'h0,        0, 0, 5'd12, 32'h401,      32'h0, 32'h0};
    vecs[13] = '{"ie_off",       32'h400,       32'h400,      32'h0,  32'h0,        0, 0, 5'd0,  32'h0,        32'h0, 32'h0};
    vecs[14] = '{"int_over_eret",32'h0,         32'h800,      32'h40, 32'h800,      0, 1, 5'd12, 32'h801,      32'h1, 32'h20};
    vecs[15] = '{"sys_epc_wr",   32'h1000_0000, 32'h0,        32'h40, 32'h100,      0, 1, 5'd14, 32'h900,      32'h8, 32'h20};

    rst = 1'b1;
    idle_inputs();
    pc = 32'h0; ds = 1'b0; status = 32'h1000_0000; cause = 32'h0; epc = 32'h0;
    repeat (2) @(negedge clk);
    check_output("reset type", excepttype_o, 32'h0);
    check_output("reset flush", {31'h0, flush_o}, 32'h0);
    check_output("reset new_pc", new_pc_o, 32'h0);
    check_output("reset busy", {31'h0, busy_o}, 32'h0);
    check_output("reset addr", current_inst_address_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      apply_stimulus(vecs[i], 32'h0000_1000 + 32'(i) * 32'h10);

    // Pending interrupt with no valid instruction in MEM must not be taken.
    @(negedge clk);
    status = 32'h401; cause = 32'h400; mem_valid = 1'b0;
    @(negedge clk);
    check_output("no_valid flush", {31'h0, flush_o}, 32'h0);
    check_output("no_valid busy", {31'h0, busy_o}, 32'h0);
    status = 32'h1000_0000; cause = 32'h0;

    // Trap followed by syscalls on the next three cycles: only the trap is taken.
    @(negedge clk);
    mem_valid = 1'b1; raw = 32'h400; pc = 32'h2000; ds = 1'b0;
    @(negedge clk);
    check_output("drain trap type", excepttype_o, 32'hd);
    check_output("drain trap flush", {31'h0, flush_o}, 32'h1);
    drive_syscall(32'h2004);
    @(negedge clk);
    check_output("drain sq1 flush", {31'h0, flush_o}, 32'h0);
    check_output("drain sq1 busy", {31'h0, busy_o}, 32'h1);
    drive_syscall(32'h2008);
    @(negedge clk);
    check_output("drain sq2 flush", {31'h0, flush_o}, 32'h0);
    check_output("drain sq2 busy", {31'h0, busy_o}, 32'h1);
    drive_syscall(32'h200c);
    @(negedge clk);
    check_output("drain sq3 flush", {31'h0, flush_o}, 32'h0);
    check_output("drain sq3 busy", {31'h0, busy_o}, 32'h0);
    idle_inputs();
    @(negedge clk);
    check_output("drain idle flush", {31'h0, flush_o}, 32'h0);
    drive_syscall(32'h2010);
    @(negedge clk);
    idle_inputs();
    check_output("after drain type", excepttype_o, 32'h8);
    check_output("after drain addr", current_inst_address_o, 32'h2010);
    check_output("after drain flush", {31'h0, flush_o}, 32'h1);

    // Asynchronous reset mid-DRAIN, then an exception on the first cycle after release.
    @(negedge clk);
    check_output("pre-rst busy", {31'h0, busy_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_output("midrst type", excepttype_o, 32'h0);
    check_output("midrst busy", {31'h0, busy_o}, 32'h0);
    check_output("midrst new_pc", new_pc_o, 32'h0);
    check_output("midrst addr", current_inst_address_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    status = 32'h1000_0000; cause = 32'h0;
    mem_valid = 1'b1; raw = 32'h200; pc = 32'h3000; ds = 1'b1;
    @(negedge clk);
    idle_inputs();
    check_output("post-rst type", excepttype_o, 32'ha);
    check_output("post-rst flush", {31'h0, flush_o}, 32'h1);
    check_output("post-rst ds", {31'h0, is_in_delayslot_o}, 32'h1);
    check_output("post-rst new_pc", new_pc_o, 32'h20);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/except_ctrl.md
# except_ctrl

MEM-stage exception controller sitting directly upstream of the CP0 register block. Combines the MEM-stage instruction's raw exception flags with pending interrupts, using CP0 Status/Cause/EPC values forwarded from any same-cycle WB-stage `mtc0`. Selects one exception by fixed priority and drives the one-cycle exception type, faulting PC and delay-slot flag into CP0. Generates the pipeline flush and redirect PC, then drains squashed instructions before accepting new exceptions.

## Interface
- `EXC_VECTOR`, 32'h0000_0020: handler entry PC for all non-eret exceptions.
- `DRAIN_CYCLES`, 2: cycles after the flush pulse during which MEM inputs are ignored; legal range 1–15.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_valid_i` in 1: a real instruction is in MEM.
- `excepttype_raw_i` in 32: bit8 syscall, bit9 invalid instruction, bit10 trap, bit11 eret; other bits ignored.
- `current_inst_address_i` in 32: MEM instruction PC.
- `is_in_delayslot_i` in 1: MEM instruction is in a delay slot.
- `cp0_status_i`, `cp0_cause_i`, `cp0_epc_i` in 32 each: current CP0 register values.
- `wb_cp0_we_i` in 1, `wb_cp0_waddr_i` in 5, `wb_cp0_data_i` in 32: the WB-stage CP0 write.
- `excepttype_o` out 32: encoded type to CP0: 0x1 interrupt, 0x8 syscall, 0xa invalid, 0xd trap, 0xe eret, 0 none.
- `current_inst_address_o` out 32, `is_in_delayslot_o` out 1: registered copies to CP0.
- `flush_o` out 1: flush all pipeline registers.
- `new_pc_o` out 32: redirect PC, valid while `flush_o` is high.
- `busy_o` out 1: high in the FLUSH and DRAIN states.

## Operation
- Forwarding: if `wb_cp0_we_i` is high and `wb_cp0_waddr_i` is 12 (Status) or 14 (EPC), the effective value is `wb_cp0_data_i`.
- If `wb_cp0_waddr_i` is 13 (Cause), the effective Cause takes bits 9:8, 22 and 23 from `wb_cp0_data_i`; all other bits come from `cp0_cause_i`.
- Interrupt pending: (Cause[15:8] & Status[15:8]) != 0, and Status[0] (IE) = 1, and Status[1] (EXL) = 0. All values are the effective (forwarded) ones.
- Priority when `mem_valid_i` is high: interrupt > syscall > invalid > trap > eret.
- EXL = 1 suppresses only the interrupt.
- The redirect PC is effective EPC for eret and `EXC_VECTOR` for every other type.
- FSM states:
  - IDLE: if `mem_valid_i` is high and any exception is selected, register the type, PC, delay-slot flag and redirect PC, then go to FLUSH. Otherwise stay in IDLE.
  - FLUSH: lasts exactly one cycle; `excepttype_o` is nonzero and `flush_o` = 1. Load the drain counter with `DRAIN_CYCLES`, then go to DRAIN.
  - DRAIN: decrement the counter each cycle; all inputs are ignored. When the counter reaches 1, go to IDLE.
- Outside FLUSH, `excepttype_o` = 0, `flush_o` = 0 and `new_pc_o` holds its last value.
- Reset (asynchronous, any state including mid-DRAIN): go to IDLE. All outputs and the counter become 0.

## Timing
- An exception presented at edge N appears at edge N+1: `excepttype_o`, `flush_o` and `new_pc_o` are valid during cycle N+1 for exactly one cycle.
- IDLE is re-entered at edge N+2+`DRAIN_CYCLES`. The next exception can be accepted at that edge plus one.
- `busy_o` is high for 1+`DRAIN_CYCLES` cycles per exception.
- A WB `mtc0` in the same cycle as the MEM decision is always forwarded. A WB write arriving one cycle later is not considered.
- If `mem_valid_i` is low, nothing is taken, including pending interrupts.
- Back-to-back exceptions on consecutive cycles: only the first is taken; the second is squashed by DRAIN.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- The shared `defines.v` holds:
  - the CP0 address constants (Status 12, Cause 13, EPC 14);
  - the exception type codes 0x1, 0x8, 0xa, 0xd and 0xe;
  - the raw flag bit positions;
  - `RstEnable`.
- FSM state encodings are local to the block.
- One natural sub-module: `cp0_fwd`, a combinational Status/Cause/EPC forwarding unit, reusable by the EX-stage `mfc0` path.

## Test plan
- Syscall: raw = 0x100, PC = 0x0000_1000, delay slot 0, Status = 0x1000_0000. Required at the next cycle: `excepttype_o` = 0x8, `new_pc_o` = 0x20, `flush_o` = 1 for one cycle, `current_inst_address_o` = 0x1000, `busy_o` high for 3 cycles.
- Eret with forwarded EPC: `cp0_epc_i` = 0x40, same-cycle WB `mtc0` EPC = 0x0000_0800. Required: type 0xe, `new_pc_o` = 0x800.
- Interrupt priority and forwarding:
  - Status = 0x0000_0401, Cause[10] = 1, raw = 0x200 → type 0x1.
  - Same stimulus with a same-cycle WB write of Status = 0x0000_0400 → type 0xa.
- EXL suppression: Status = 0x0000_0403 with the interrupt pending and raw = 0 → no flush. Adding raw = 0x400 → type 0xd.
- Drain and reset:
  - Trap followed by syscalls on the next 3 cycles (`DRAIN_CYCLES` = 2): only the trap is taken; the syscall two cycles after DRAIN ends is taken.
  - `rst` asserted mid-DRAIN: outputs 0 immediately, state IDLE, and an exception is accepted on the first cycle after reset release.
